pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher_pkg.sv | 19 +
 rtl/stretch_counter.sv | 30 +++
 rtl/pulse_stretcher.sv | 125 ++++++++++++
 tb/tb_pulse_stretcher.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and counter sizing for pulse_stretcher.
// cnt_width() sizes the hold/gap down-counter for the larger of the two window lengths.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(4, 2);

endpackage

// File: rtl/stretch_counter.sv
// Loadable down-counter that saturates at zero; load wins over enable.
// count is registered; zero is decoded from the registered count.
module stretch_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches each accepted request into a HOLD_CYCLES-high window, spaced by GAP_CYCLES low cycles.
// First window starts one edge after the request; extra requests queue up to MAX_PENDING, beyond that they are dropped.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pulse,
  output logic                               out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int CNT_W  = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic [CNT_W-1:0]   w_count;
  logic               w_zero;
  logic               w_enq;
  logic               w_deq;
  logic               w_full;
  logic               w_drop;
  logic               r_out;
  logic [PEND_W-1:0]  r_pending;
  logic               r_overflow;

  stretch_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (r_state != ST_IDLE),
    .count    (w_count),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= (w_state_nxt == ST_HOLD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_enq       = 1'b0;
    w_deq       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pulse) begin
          w_state_nxt = ST_HOLD;
          w_load      = 1'b1;
          w_load_val  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        w_enq = pulse;
        if (w_zero) begin
          w_state_nxt = ST_GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (!w_zero) begin
          w_enq = pulse;
        end else if ((r_pending != '0) || pulse) begin
          w_state_nxt = ST_HOLD;
          w_load      = 1'b1;
          w_load_val  = HOLD_LOAD;
          // With nothing queued, a pulse on the last gap cycle is serviced directly.
          if (r_pending != '0) begin
            w_deq = 1'b1;
            w_enq = pulse;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_full = (r_pending == PEND_MAX);
  assign w_drop = w_enq && !w_deq && w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_enq && !w_deq && !w_full) begin
        r_pending <= r_pending + 1'b1;
      end else if (w_deq && !w_enq) begin
        r_pending <= r_pending - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out      = r_out;
  assign busy     = (r_state != ST_IDLE);
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher at HOLD=4, GAP=2, MAX_PENDING=3.
// Traces are 32 cycles, MSB = first cycle after the first stimulus edge.
module tb_pulse_stretcher;

  logic       clk;
  logic       reset;
  logic       pulse;
  logic       out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks;
  int failures;

  logic [31:0] ot;
  logic [31:0] bt;
  int          pmax;

  pulse_stretcher #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .MAX_PENDING (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse    (pulse),
    .out      (out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply pat MSB-first, one bit per edge, and record out/busy/peak pending.
  task automatic run(input logic [31:0] pat, output logic [31:0] o_tr,
                     output logic [31:0] b_tr, output int p_max);
    o_tr  = '0;
    b_tr  = '0;
    p_max = 0;
    for (int i = 0; i < 32; i++) begin
      pulse = pat[31-i];
      @(posedge clk);
      #1;
      o_tr = {o_tr[30:0], out};
      b_tr = {b_tr[30:0], busy};
      if (int'(pending) > p_max) p_max = int'(pending);
    end
    pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    pulse    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",      {31'b0, out},      32'h0);
    check("rst_busy",     {31'b0, busy},     32'h0);
    check("rst_pending",  {30'b0, pending},  32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);
    reset = 1'b0;

    // Single pulse: four high cycles, busy through the two gap cycles.
    run(32'h8000_0000, ot, bt, pmax);
    check("single_out",  ot, 32'hF000_0000);
    check("single_busy", bt, 32'hFC00_0000);
    check("single_pmax", pmax, 32'd0);

    // Pulse held three cycles: three windows, gap of two.
    do_reset();
    run(32'hE000_0000, ot, bt, pmax);
    check("held3_out",  ot, 32'hF3CF_0000);
    check("held3_pmax", pmax, 32'd2);
    check("held3_ovf",  {31'b0, overflow}, 32'h0);

    // Six back-to-back: saturate at 3, two dropped, four windows.
    do_reset();
    run(32'hFC00_0000, ot, bt, pmax);
    check("six_out",  ot, 32'hF3CF_3C00);
    check("six_pmax", pmax, 32'd3);
    check("six_ovf",  {31'b0, overflow}, 32'h1);

    // Overflow is sticky: a further burst is queued, overflow still high, then reset mid-HOLD.
    for (int i = 0; i < 3; i++) begin
      pulse = 1'b1;
      @(posedge clk);
      #1;
    end
    pulse = 1'b0;
    check("mid_pending",  {30'b0, pending},  32'h2);
    check("mid_ovf_stky", {31'b0, overflow}, 32'h1);
    check("mid_out",      {31'b0, out},      32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_out",      {31'b0, out},      32'h0);
    check("async_busy",     {31'b0, busy},     32'h0);
    check("async_pending",  {30'b0, pending},  32'h0);
    check("async_overflow", {31'b0, overflow}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(32'h0, ot, bt, pmax);
    check("post_rst_out",  ot, 32'h0);
    check("post_rst_busy", bt, 32'h0);

    // Pulse on the last gap cycle with nothing queued: straight back to HOLD.
    do_reset();
    run(32'h8200_0000, ot, bt, pmax);
    check("lastgap_out",  ot, 32'hF3C0_0000);
    check("lastgap_busy", bt, 32'hFFF0_0000);
    check("lastgap_pmax", pmax, 32'd0);

    // Pulse on the first gap cycle is queued, then dequeued.
    do_reset();
    run(32'h8400_0000, ot, bt, pmax);
    check("firstgap_out",  ot, 32'hF3C0_0000);
    check("firstgap_pmax", pmax, 32'd1);

    // Pulse on the very first edge after reset release is honoured.
    do_reset();
    run(32'h8000_0000, ot, bt, pmax);
    check("first_edge_out", ot, 32'hF000_0000);
    check("first_edge_ovf", {31'b0, overflow}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
